// File: rtl/marker_event_encoder.sv
// Turns ROB phase-marker instructions (slti x0, x0, N) into timestamped records
// on a valid/ready stream, and tracks the committed phase plus protocol errors.
module marker_event_encoder #(
    parameter int TS_W   = 48,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enq_valid,
    input  logic [31:0]       enq_inst,
    input  logic              commit_valid,
    input  logic [31:0]       commit_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TS_W+4:0]   out_data,
    output logic [2:0]        phase,
    output logic              proto_err,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = TS_W + 5;

    logic [TS_W-1:0]   ts;
    logic [RW-1:0]     mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic              enq_hit;
    logic              com_hit;
    logic [RW-1:0]     rec_first;
    logic [RW-1:0]     rec_second;
    logic [1:0]        needed;
    logic [CW-1:0]     free;
    logic [1:0]        n_write;
    logic [1:0]        n_drop;
    logic              pop;
    logic [DROP_W:0]   drop_sum;
    logic [3:0]        cid;
    logic [2:0]        target;

    function automatic logic is_marker(input logic valid, input logic [31:0] inst);
        return valid && inst[31:24] == 8'h00 && inst[19:0] == 20'h02013
               && inst[23:20] <= 4'hD;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        n_write    = 2'd0;
        enq_hit    = is_marker(enq_valid, enq_inst);
        com_hit    = is_marker(commit_valid, commit_inst);
        rec_first  = enq_hit ? {1'b0, enq_inst[23:20], ts} : {1'b1, commit_inst[23:20], ts};
        rec_second = {1'b1, commit_inst[23:20], ts};
        needed     = {1'b0, enq_hit} + {1'b0, com_hit};
        // Space is judged on pre-pop occupancy; a same-cycle pop helps only next cycle.
        free       = CW'(DEPTH) - count;
        if (free >= CW'(needed))
            n_write = needed;
        else
            n_write = free[1:0];
        n_drop     = needed - n_write;
        drop_sum   = {1'b0, drop_cnt} + (DROP_W + 1)'(n_drop);
        cid        = commit_inst[23:20];
        target     = cid[3:1] + 3'd1;
    end

    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // NOTE: storage is not reset; count==0 makes stale entries unobservable.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (n_write != 2'd0)
                mem[wr_ptr] <= rec_first;
            if (n_write == 2'd2)
                mem[wr_ptr + PW'(1)] <= rec_second;
        end
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ts        <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            phase     <= 3'd0;
            proto_err <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            ts     <= ts + TS_W'(1);
            wr_ptr <= wr_ptr + PW'(n_write);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(n_write) - CW'(pop);

            if (n_drop != 2'd0) begin
                overflow <= 1'b1;
                drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
            end

            // Only committed markers move the phase; enqueue markers are speculative.
            if (com_hit) begin
                if (!cid[0]) begin
                    if (phase != 3'd0)
                        proto_err <= 1'b1;
                    phase <= target;
                end else if (phase == target) begin
                    phase <= 3'd0;
                end else begin
                    proto_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_marker_event_encoder.sv
// Self-checking bench for marker_event_encoder: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_marker_event_encoder;

    // Narrow timestamp and drop counter so wrap and saturation are reached quickly.
    localparam int TS_W   = 8;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 4;
    localparam int RW     = TS_W + 5;
    localparam int MAXD   = (1 << DROP_W) - 1;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              enq_valid = 1'b0;
    logic [31:0]       enq_inst = 32'h0;
    logic              commit_valid = 1'b0;
    logic [31:0]       commit_inst = 32'h0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [RW-1:0]     out_data;
    logic [2:0]        phase;
    logic              proto_err;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] m_q[$];
    int            m_ts = 0;
    int            m_phase = 0;
    bit            m_err = 0;
    bit            m_ovf = 0;
    int            m_drops = 0;

    marker_event_encoder #(.TS_W(TS_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_inst(enq_inst),
        .commit_valid(commit_valid), .commit_inst(commit_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .phase(phase), .proto_err(proto_err), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clock = ~clock;

    function automatic bit is_marker(input logic v, input logic [31:0] inst);
        return v && inst[31:24] == 8'h00 && inst[19:0] == 20'h02013 && int'(inst[23:20]) <= 13;
    endfunction

    function automatic logic [RW-1:0] exp_head();
        return (m_q.size() != 0) ? m_q[0] : '0;
    endfunction

    function automatic logic [RW-1:0] mk(input bit c, input int id, input int t);
        return {c, 4'(id), TS_W'(t)};
    endfunction

    // Advance the model by one cycle from the current inputs, then the DUT by one edge.
    task automatic step();
        logic [RW-1:0] recs[$];
        int free;
        int id;
        if (!reset) begin
            m_q.delete();
            m_ts = 0; m_phase = 0; m_err = 0; m_ovf = 0; m_drops = 0;
        end else begin
            if (is_marker(enq_valid, enq_inst))
                recs.push_back(mk(1'b0, int'(enq_inst[23:20]), m_ts));
            if (is_marker(commit_valid, commit_inst))
                recs.push_back(mk(1'b1, int'(commit_inst[23:20]), m_ts));
            free = DEPTH - m_q.size();
            if (m_q.size() != 0 && out_ready)
                void'(m_q.pop_front());
            foreach (recs[i]) begin
                if (free > 0) begin
                    m_q.push_back(recs[i]);
                    free--;
                end else begin
                    m_ovf = 1;
                    if (m_drops < MAXD) m_drops++;
                end
            end
            if (is_marker(commit_valid, commit_inst)) begin
                id = int'(commit_inst[23:20]);
                if (id % 2 == 0) begin
                    if (m_phase != 0) m_err = 1;
                    m_phase = id / 2 + 1;
                end else if (m_phase == (id - 1) / 2 + 1) begin
                    m_phase = 0;
                end else begin
                    m_err = 1;
                end
            end
            m_ts = (m_ts + 1) % (1 << TS_W);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid = 1'b0; enq_inst = 32'h0;
        commit_valid = 1'b0; commit_inst = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || phase !== 3'd0 || proto_err !== 1'b0
            || overflow !== 1'b0 || drop_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b data=%h phase=%0d err=%0b ovf=%0b drop=%0d, expected all zero",
                     out_valid, out_data, phase, proto_err, overflow, drop_cnt);
        end
        reset = 1'b1;
        repeat (4) step();
        enq_valid = 1'b1; enq_inst = 32'h0000_2013;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_latency: out_valid=%0b before record cycle, expected 0", out_valid);
        end
        step();
        idle_inputs();
        checks++;
        if (out_valid !== 1'b1 || out_data !== mk(1'b0, 0, 4)) begin
            errors++;
            $display("FAIL first_record: valid=%0b data=%h, expected 1 %h", out_valid, out_data, mk(1'b0, 0, 4));
        end
        checks++;
        if (phase !== 3'd0) begin
            errors++;
            $display("FAIL enq_no_phase: phase=%0d expected 0", phase);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_pop: out_valid=%0b expected 0", out_valid);
        end
    endtask

    task automatic test_phase();
        commit_valid = 1'b1; commit_inst = 32'h0080_2013;
        step();
        checks++;
        if (phase !== 3'd5) begin
            errors++;
            $display("FAIL phase_init_start: phase=%0d expected 5", phase);
        end
        commit_inst = 32'h0090_2013;
        step();
        idle_inputs();
        checks++;
        if (phase !== 3'd0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL phase_init_end: phase=%0d err=%0b expected 0 0", phase, proto_err);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data[RW-1] !== 1'b1 || out_data[RW-2:TS_W] !== 4'd8) begin
            errors++;
            $display("FAIL commit_rec8: data=%h expected is_commit=1 id=8", out_data);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data[RW-1] !== 1'b1 || out_data[RW-2:TS_W] !== 4'd9) begin
            errors++;
            $display("FAIL commit_rec9: data=%h expected is_commit=1 id=9", out_data);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_dual();
        int t;
        t = m_ts;
        enq_valid = 1'b1; enq_inst = 32'h00c0_2013;
        commit_valid = 1'b1; commit_inst = 32'h00a0_2013;
        out_ready = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (out_data !== mk(1'b0, 12, t) || phase !== 3'd6) begin
            errors++;
            $display("FAIL dual_head: data=%h phase=%0d expected %h 6", out_data, phase, mk(1'b0, 12, t));
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== mk(1'b1, 10, t)) begin
            errors++;
            $display("FAIL dual_second: valid=%0b data=%h expected 1 %h", out_valid, out_data, mk(1'b1, 10, t));
        end
        commit_valid = 1'b1; commit_inst = 32'h00b0_2013;
        step();
        idle_inputs();
        step();
        checks++;
        if (phase !== 3'd0 || proto_err !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dual_close: phase=%0d err=%0b valid=%0b expected 0 0 0", phase, proto_err, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [RW-1:0] head;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            enq_valid = 1'b1; enq_inst = {8'h00, 4'(i), 20'h02013};
            step();
            if (i == 0) head = out_data;
            checks++;
            if (out_data !== head) begin
                errors++;
                $display("FAIL stall_stable %0d: data=%h expected %h", i, out_data, head);
            end
        end
        idle_inputs();
        checks++;
        if (drop_cnt !== DROP_W'(2) || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_cnt: drop=%0d ovf=%0b expected 2 1", drop_cnt, overflow);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data[RW-1] !== 1'b0 || out_data[RW-2:TS_W] !== 4'(i)) begin
                errors++;
                $display("FAIL overflow_order %0d: valid=%0b data=%h expected enqueue id %0d", i, out_valid, out_data, i);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL overflow_drain: out_valid=%0b expected 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_proto();
        commit_valid = 1'b1; commit_inst = 32'h0030_2013;
        step();
        checks++;
        if (proto_err !== 1'b1 || phase !== 3'd0) begin
            errors++;
            $display("FAIL proto_idle_end: err=%0b phase=%0d expected 1 0", proto_err, phase);
        end
        commit_inst = 32'h0000_2013;
        step();
        checks++;
        if (phase !== 3'd1) begin
            errors++;
            $display("FAIL proto_start: phase=%0d expected 1", phase);
        end
        commit_inst = 32'h0040_2013;
        step();
        idle_inputs();
        checks++;
        if (phase !== 3'd3 || proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_nested: phase=%0d err=%0b expected 3 1", phase, proto_err);
        end
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
    endtask

    task automatic test_ignored_and_reset();
        enq_valid = 1'b1; enq_inst = 32'h00e0_2013;
        step();
        enq_inst = 32'h0001_2013;
        step();
        idle_inputs();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignored_inst: out_valid=%0b expected 0", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1; enq_inst = {8'h00, 4'(i + 2), 20'h02013};
            step();
        end
        idle_inputs();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL queued_before_reset: out_valid=%0b expected 1", out_valid);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || phase !== 3'd0 || proto_err !== 1'b0
            || overflow !== 1'b0 || drop_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset: valid=%0b data=%h phase=%0d err=%0b ovf=%0b drop=%0d, expected all zero",
                     out_valid, out_data, phase, proto_err, overflow, drop_cnt);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] m;
        m = {8'h00, 4'($urandom_range(0, 15)), 20'h02013};
        case ($urandom_range(0, 3))
            0, 1:    return m;
            2:       return m ^ (32'h1 << $urandom_range(0, 31));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        int ready_pct;
        ready_pct = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 150 == 0) ready_pct = (cyc % 450 == 0) ? 10 : ((cyc % 450 == 150) ? 50 : 95);
            reset        = ($urandom_range(0, 599) != 0);
            enq_valid    = $urandom_range(0, 1) == 1;
            enq_inst     = rand_inst();
            commit_valid = $urandom_range(0, 1) == 1;
            commit_inst  = rand_inst();
            out_ready    = $urandom_range(0, 99) < ready_pct;
            step();
            checks++;
            if (out_valid !== (m_q.size() != 0)) begin
                errors++;
                $display("FAIL rand_valid cyc %0d: got %0b expected %0b", cyc, out_valid, m_q.size() != 0);
            end
            checks++;
            if (out_data !== exp_head()) begin
                errors++;
                $display("FAIL rand_data cyc %0d: got %h expected %h", cyc, out_data, exp_head());
            end
            checks++;
            if (phase !== 3'(m_phase) || proto_err !== m_err) begin
                errors++;
                $display("FAIL rand_phase cyc %0d: got phase=%0d err=%0b expected %0d %0b",
                         cyc, phase, proto_err, m_phase, m_err);
            end
            checks++;
            if (overflow !== m_ovf || drop_cnt !== DROP_W'(m_drops)) begin
                errors++;
                $display("FAIL rand_drop cyc %0d: got ovf=%0b drop=%0d expected %0b %0d",
                         cyc, overflow, drop_cnt, m_ovf, m_drops);
            end
        end
        reset = 1'b1;
        idle_inputs();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_phase();
        test_dual();
        test_overflow();
        test_proto();
        test_ignored_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/marker_event_encoder.md
Name: marker_event_encoder

Overview:
- Synthesizable producer of the phase-marker event stream that the simulation harness consumes.
- Sits beside the core's ROB. It watches ROB enqueue and commit slot 0 for marker instructions `slti x0, x0, N` (encoding 0x00N02013).
- Each marker becomes a timestamped record in a small FIFO, drained over a valid/ready port.
- Also tracks the current committed phase and flags protocol errors: nested start, or an end that does not match.

Parameters:
- TS_W, 48, width of the free-running cycle timestamp.
- DEPTH, 8, record FIFO depth; power of two, ≥2.
- DROP_W, 16, width of the saturating dropped-record counter.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- enq_valid  in  1  ROB enqueue slot 0 valid.
- enq_inst  in  32  ROB enqueue slot 0 debug instruction.
- commit_valid  in  1  ROB commit slot 0 valid.
- commit_inst  in  32  ROB commit slot 0 debug instruction.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts record.
- out_data  out  5+TS_W  record: {is_commit[1], id[4], timestamp[TS_W]}.
- phase  out  3  current committed phase: 0 idle, else id[3:1]+1.
- proto_err  out  1  sticky protocol error.
- overflow  out  1  sticky FIFO-overflow flag.
- drop_cnt  out  DROP_W  records dropped, saturating.

Behaviour:
- Reset is sampled on posedge clock while reset==0. It clears:
  - the timestamp counter;
  - the FIFO (out_valid=0, out_data=0);
  - phase=0, proto_err=0, overflow=0, drop_cnt=0.
- Reset mid-operation discards all queued records.
- Timestamp:
  - ts increments by 1 every cycle out of reset; it is 0 in the first cycle after reset release.
  - It wraps modulo 2^TS_W.
  - A record carries the ts value of the cycle in which its input was sampled.
- Marker decode, combinational per slot:
  - Marker iff valid && inst[31:24]==8'h00 && inst[19:0]==20'h02013 && inst[23:20]<=4'hD; id = inst[23:20].
  - ids 0xE and 0xF are ignored, as is any non-marker instruction.
- Event ids: 0/1 VCTM, 2/3 DELAY, 4/5 TEXE, 6/7 LEAK, 8/9 INIT, 10/11 BIM, 12/13 TRAIN. Even id = start, odd id = end.
- FIFO write rules:
  - Up to 2 writes per cycle. When both slots carry markers, the enqueue record (is_commit=0) is ordered before the commit record (is_commit=1).
  - Free space is computed before this cycle's pop.
  - If free ≥ needed, all records are written.
  - If free==1 and 2 records are pending, the enqueue record is written and the commit record dropped.
  - If free==0, all pending records are dropped.
  - Each dropped record increments drop_cnt (+1 or +2, saturating at all-ones) and sets overflow.
- Output handshake:
  - out_data holds the FIFO head and is stable while out_valid && !out_ready.
  - A pop occurs when out_valid && out_ready.
  - A record written into an empty FIFO becomes visible on out_valid one cycle after its input cycle (1-cycle latency).
  - No bypass in the same cycle.
  - Pop and push in the same cycle on a full FIFO: the pop frees space only for the next cycle; push is judged on pre-pop occupancy.
- Phase FSM (commit markers only; enqueue markers never change phase):
  - Start id s, phase==0: phase <= s/2+1.
  - Start id while phase!=0 (nested): proto_err <= 1, phase <= s/2+1.
  - End id e with phase==(e-1)/2+1: phase <= 0.
  - End id with mismatched or idle phase: proto_err <= 1, phase unchanged.
- Sticky flags clear only on reset.

Test Plan:
- Reset held low 3 cycles, then released; enq_valid=1, enq_inst=0x00002013 in the 5th cycle after release → one record {0, 0x0, ts=4}; out_valid rises the next cycle; phase stays 0.
- commit_inst=0x00802013, then 0x00902013 on later cycles → phase goes 0→5→0; two records with is_commit=1, ids 8 and 9; proto_err=0.
- Same cycle: enq_inst=0x00c02013 and commit_inst=0x00a02013, out_ready=1 → head is {0, 0xC, t}, next record is {1, 0xA, t}; phase=6.
- out_ready=0 with 10 distinct markers at DEPTH=8 → 8 records kept in order; drop_cnt=2; overflow=1; out_data unchanged while stalled.
- Commit 0x00302013 while phase==0 → proto_err=1, phase=0. Then commit 0x00002013, then 0x00402013 → phase=1, then phase=3, proto_err stays 1.
- enq_inst=0x00e02013, then 0x00012013 (rs1≠0) → no record; reset asserted with 4 records queued → out_valid=0 the cycle after reset.
